host_reg_bridge: RTL and testbench
==================================

HOST_REG_BRIDGE -- requirements
Module: HOST_REG_BRIDGE

Interface
REQ-001 SHALL have parameter WE_WIDTH, default 16: number of one-hot write-strobe bits.
REQ-002 SHALL have parameter RE_WIDTH, default 16: number of one-hot read-select bits.
REQ-003 SHALL have parameter C_TO_WH, default 16: width of the inter-byte timeout counter.
REQ-004 SHALL have ports, in this order:
- CLK  in  1  sole clock.
- RST_N  in  1  reset; synchronous, active-low.
- iRX_DATA  in  8  command/data byte from the host receiver.
- iRX_VALID  in  1  iRX_DATA valid.
- oRX_READY  out  1  bridge accepts a byte.
- oTX_DATA  out  8  read-response byte.
- oTX_VALID  out  1  oTX_DATA valid.
- iTX_READY  in  1  transmitter accepts the byte.
- oWE_BIT  out  WE_WIDTH  one-hot write strobe to register blocks.
- oRE_BIT  out  RE_WIDTH  one-hot read select to register blocks.
- oDATA  out  8  write data to register blocks.
- iRD  in  8  OR-combined read data from register blocks.
- oBUSY  out  1  high whenever state is not IDLE.
- oERR_CNT  out  8  saturating protocol-error count.

Function
REQ-005 SHALL transfer a byte when iRX_VALID and oRX_READY are both high on a rising CLK edge.
REQ-006 SHALL decode the command byte as: bit7 = 1 write / 0 read; bits[6:5] reserved, must be 00; bits[4:0] = register address.
REQ-007 SHALL implement exactly the states IDLE, WDATA, WSTB, RSTB and TX.
REQ-008 IDLE: oRX_READY=1.
- Command with bits[6:5]!=00: SHALL increment the error count and stay in IDLE.
- Write command: SHALL latch the address and go to WDATA.
- Read command: SHALL latch the address and go to RSTB.
REQ-009 WDATA: oRX_READY=1.
- Byte accepted: SHALL load oDATA and go to WSTB.
- No byte for 2^C_TO_WH-1 consecutive cycles: SHALL increment the error count and return to IDLE.
REQ-010 WSTB: SHALL assert oWE_BIT[addr] alone for exactly one cycle with oDATA valid, then go to IDLE.
- addr >= WE_WIDTH: oWE_BIT stays all-zero and the error count increments.
REQ-011 oDATA SHALL hold its value until the next accepted write-data byte.
REQ-012 RSTB: SHALL assert oRE_BIT[addr] alone for exactly one cycle, sample iRD into the TX register at the end of that cycle, then go to TX.
- addr >= RE_WIDTH: oRE_BIT stays zero, the response byte is 0x00, and the error count increments.
REQ-013 TX: oTX_VALID=1 with oTX_DATA stable until iTX_READY is high, then go to IDLE.
REQ-014 oRX_READY SHALL be 0 in WSTB, RSTB and TX; host bytes arriving then are not consumed.
REQ-015 Latency, all outputs registered:
- Write: oWE_BIT pulses in the cycle after the data byte is accepted.
- Read: oRE_BIT is high in the cycle after the command is accepted; oTX_VALID rises one cycle later.
REQ-016 The timeout counter SHALL clear on every accepted byte and on every entry to WDATA.
REQ-017 oERR_CNT SHALL saturate at 0xFF and never wrap.
REQ-018 A protocol error that coincides with a new accepted byte SHALL count once, and the byte SHALL be processed normally.

Reset
REQ-019 With RST_N low at a rising edge, the block SHALL set:
- state IDLE;
- oWE_BIT, oRE_BIT, oDATA, oTX_DATA, oTX_VALID, oERR_CNT and the timeout counter to 0;
- oRX_READY to 0 while RST_N is low.
REQ-020 Reset mid-frame SHALL discard the partial command and any pending response without emitting a strobe.

Structure
REQ-021 A shared package SHALL hold the state encoding, the command field positions (RW bit, reserved field, address field) and the 8-bit data width constant.
REQ-022 The inter-byte timeout counter SHALL be a separate sub-module, BYTE_TIMEOUT, with clear, enable and expiry signals.

Verification
REQ-023 Bytes 0x83,0x5A with iTX_READY=1 -> oDATA=0x5A, oWE_BIT=0x0008 for exactly one cycle, no TX byte.
REQ-024 Byte 0x02 with iRD=0x3C while oRE_BIT=0x0004 -> oRE_BIT high one cycle, then oTX_DATA=0x3C with oTX_VALID held through 5 cycles of iTX_READY=0.
REQ-025 Byte 0xA1 -> no strobe, oERR_CNT=1; then byte 0x1F (addr >= RE_WIDTH) -> response 0x00, oERR_CNT=2.
REQ-026 Byte 0x81, then no byte for 2^C_TO_WH-1 cycles -> back to IDLE, oERR_CNT+1, no oWE_BIT; a later 0x81,0x11 writes normally.
REQ-027 RST_N low during WDATA and during TX -> all outputs 0, no strobe; 300 reserved-bit commands -> oERR_CNT=0xFF.

Source files
------------

// File: rtl/host_reg_bridge_pkg.sv
// Shared definitions for the host register bridge: FSM encoding,
// command byte field layout and data width.
package host_reg_bridge_pkg;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 5;

    // Command byte layout: [7] rw, [6:5] reserved (must be 0), [4:0] address
    localparam int CMD_RW_BIT  = 7;
    localparam int CMD_RSV_HI  = 6;
    localparam int CMD_RSV_LO  = 5;
    localparam int CMD_ADDR_HI = 4;
    localparam int CMD_ADDR_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_WSTB  = 3'd2,
        S_RSTB  = 3'd3,
        S_TX    = 3'd4
    } state_t;

    // A command is well formed only when its reserved field is all zero.
    function automatic logic cmd_rsv_ok(input logic [DATA_W-1:0] cmd);
        return cmd[CMD_RSV_HI:CMD_RSV_LO] == '0;
    endfunction

endpackage

// File: rtl/host_reg_bridge_byte_timeout.sv
// Inter-byte timeout counter. Counts cycles while enabled; expired is
// high in the (2^W-1)th consecutive enabled cycle without a clear.
module host_reg_bridge_byte_timeout #(
    parameter int W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Last count value before the budget is exhausted: 2^W-2
    localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] cnt;

    // Count enabled cycles; clear has priority so a fresh byte restarts the window.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // Expiry is seen even if a byte arrives in the same cycle, so the
    // top can count that error while still taking the byte.
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/host_reg_bridge.sv
// Byte-serial host to register-block bridge. A command byte selects
// read or write and a 5-bit address; writes take one data byte and pulse
// a one-hot strobe, reads pulse a one-hot select and return one byte.
module host_reg_bridge
    import host_reg_bridge_pkg::*;
#(
    parameter int WE_WIDTH = 16,
    parameter int RE_WIDTH = 16,
    parameter int C_TO_WH  = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [DATA_W-1:0]   iRX_DATA,
    input  logic                iRX_VALID,
    output logic                oRX_READY,
    output logic [DATA_W-1:0]   oTX_DATA,
    output logic                oTX_VALID,
    input  logic                iTX_READY,
    output logic [WE_WIDTH-1:0] oWE_BIT,
    output logic [RE_WIDTH-1:0] oRE_BIT,
    output logic [DATA_W-1:0]   oDATA,
    input  logic [DATA_W-1:0]   iRD,
    output logic                oBUSY,
    output logic [DATA_W-1:0]   oERR_CNT
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WE_WIDTH-1:0] we_d;
    logic [RE_WIDTH-1:0] re_d;
    logic [DATA_W-1:0]   data_d, tx_data_d;
    logic                tx_valid_d;
    logic                err_inc;
    logic                rx_fire;
    logic                to_clr, to_en, to_expired;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_addr_re_ok, addr_we_ok, addr_re_ok;

    // Bytes are only taken while waiting for a command or write data.
    assign oRX_READY = RST_N && (state_q == S_IDLE || state_q == S_WDATA);
    assign rx_fire   = iRX_VALID && oRX_READY;
    assign oBUSY     = (state_q != S_IDLE);

    assign cmd_addr       = iRX_DATA[CMD_ADDR_HI:CMD_ADDR_LO];
    assign cmd_addr_re_ok = int'(cmd_addr) < RE_WIDTH;
    assign addr_we_ok     = int'(addr_q) < WE_WIDTH;
    assign addr_re_ok     = int'(addr_q) < RE_WIDTH;

    // Window runs only in WDATA and restarts on every accepted byte.
    assign to_en  = (state_q == S_WDATA);
    assign to_clr = rx_fire || (state_q != S_WDATA);

    host_reg_bridge_byte_timeout #(.W(C_TO_WH)) u_timeout (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // Next state and next registered outputs; strobes default low so they pulse.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = '0;
        re_d       = '0;
        data_d     = oDATA;
        tx_data_d  = oTX_DATA;
        tx_valid_d = oTX_VALID;
        err_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (!cmd_rsv_ok(iRX_DATA)) begin
                        err_inc = 1'b1;
                    end else if (iRX_DATA[CMD_RW_BIT]) begin
                        addr_d  = cmd_addr;
                        state_d = S_WDATA;
                    end else begin
                        addr_d  = cmd_addr;
                        state_d = S_RSTB;
                        if (cmd_addr_re_ok)
                            re_d = RE_WIDTH'(1) << cmd_addr;
                    end
                end
            end
            S_WDATA: begin
                // A timeout coinciding with a byte is counted but the byte still wins.
                if (to_expired)
                    err_inc = 1'b1;
                if (rx_fire) begin
                    data_d  = iRX_DATA;
                    state_d = S_WSTB;
                    if (addr_we_ok)
                        we_d = WE_WIDTH'(1) << addr_q;
                end else if (to_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_WSTB: begin
                if (!addr_we_ok)
                    err_inc = 1'b1;
                state_d = S_IDLE;
            end
            S_RSTB: begin
                tx_data_d  = addr_re_ok ? iRD : '0;
                tx_valid_d = 1'b1;
                err_inc    = !addr_re_ok;
                state_d    = S_TX;
            end
            S_TX: begin
                if (iTX_READY) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and all outputs are registered; reset drops any partial frame.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            oWE_BIT   <= '0;
            oRE_BIT   <= '0;
            oDATA     <= '0;
            oTX_DATA  <= '0;
            oTX_VALID <= 1'b0;
            oERR_CNT  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            oWE_BIT   <= we_d;
            oRE_BIT   <= re_d;
            oDATA     <= data_d;
            oTX_DATA  <= tx_data_d;
            oTX_VALID <= tx_valid_d;
            if (err_inc && oERR_CNT != 8'hFF)
                oERR_CNT <= oERR_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_host_reg_bridge.sv
// Bench for host_reg_bridge: a behavioural model predicts every output each
// cycle, and directed sequences add literal checks on key results.
module tb_host_reg_bridge;

    localparam int WEW    = 16;
    localparam int REW    = 16;
    localparam int TOW    = 6;
    localparam int TO_CYC = (1 << TOW) - 1;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  iRX_DATA = 8'h00;
    logic        iRX_VALID = 1'b0;
    logic        oRX_READY;
    logic [7:0]  oTX_DATA;
    logic        oTX_VALID;
    logic        iTX_READY = 1'b1;
    logic [15:0] oWE_BIT;
    logic [15:0] oRE_BIT;
    logic [7:0]  oDATA;
    logic [7:0]  iRD;
    logic        oBUSY;
    logic [7:0]  oERR_CNT;

    logic [7:0]  rd_val = 8'h00;

    host_reg_bridge #(.WE_WIDTH(WEW), .RE_WIDTH(REW), .C_TO_WH(TOW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .iRX_DATA(iRX_DATA), .iRX_VALID(iRX_VALID), .oRX_READY(oRX_READY),
        .oTX_DATA(oTX_DATA), .oTX_VALID(oTX_VALID), .iTX_READY(iTX_READY),
        .oWE_BIT(oWE_BIT), .oRE_BIT(oRE_BIT), .oDATA(oDATA), .iRD(iRD),
        .oBUSY(oBUSY), .oERR_CNT(oERR_CNT)
    );

    always #5 CLK = ~CLK;

    // Register blocks answer only while selected; otherwise a poison value.
    assign iRD = (oRE_BIT != 16'h0) ? rd_val : 8'hEE;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_WDATA = 1, M_WSTB = 2, M_RSTB = 3, M_TX = 4;
    int          m_st   = M_IDLE;
    int          m_addr = 0;
    int          m_idle = 0;
    logic [15:0] e_we   = '0;
    logic [15:0] e_re   = '0;
    logic [7:0]  e_data = '0;
    logic [7:0]  e_txd  = '0;
    logic        e_txv  = 1'b0;
    logic [7:0]  e_err  = '0;
    logic        e_ready, m_acc;

    assign e_ready = RST_N && (m_st == M_IDLE || m_st == M_WDATA);
    assign m_acc   = iRX_VALID && e_ready;

    function automatic logic [7:0] bump(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_st <= M_IDLE; m_addr <= 0; m_idle <= 0;
            e_we <= '0; e_re <= '0; e_data <= '0; e_txd <= '0; e_txv <= 1'b0; e_err <= '0;
        end else begin
            e_we <= '0;
            e_re <= '0;
            case (m_st)
                M_IDLE: if (m_acc) begin
                    if (iRX_DATA[6:5] != 2'b00) e_err <= bump(e_err);
                    else begin
                        m_addr <= int'(iRX_DATA[4:0]);
                        m_idle <= 0;
                        if (iRX_DATA[7]) m_st <= M_WDATA;
                        else begin
                            m_st <= M_RSTB;
                            if (int'(iRX_DATA[4:0]) < REW) e_re <= 16'h1 << iRX_DATA[4:0];
                        end
                    end
                end
                M_WDATA: begin
                    if (m_acc) begin
                        e_data <= iRX_DATA;
                        m_st   <= M_WSTB;
                        if (m_addr < WEW) e_we <= 16'h1 << m_addr;
                        if (m_idle == TO_CYC - 1) e_err <= bump(e_err);
                    end else if (m_idle == TO_CYC - 1) begin
                        e_err <= bump(e_err);
                        m_st  <= M_IDLE;
                    end else begin
                        m_idle <= m_idle + 1;
                    end
                end
                M_WSTB: begin
                    if (m_addr >= WEW) e_err <= bump(e_err);
                    m_st <= M_IDLE;
                end
                M_RSTB: begin
                    e_txd <= (m_addr < REW) ? rd_val : 8'h00;
                    e_txv <= 1'b1;
                    if (m_addr >= REW) e_err <= bump(e_err);
                    m_st <= M_TX;
                end
                M_TX: if (iTX_READY) begin
                    e_txv <= 1'b0;
                    m_st  <= M_IDLE;
                end
                default: m_st <= M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    int          we_cycles = 0, re_cycles = 0, tx_cnt = 0;
    logic [15:0] last_we = '0, last_re = '0;
    logic [7:0]  last_txd = '0;

    always @(negedge CLK) begin
        chk("rx_ready", oRX_READY, e_ready);
        chk("busy",     oBUSY,     (m_st != M_IDLE));
        chk("we_bit",   oWE_BIT,   e_we);
        chk("re_bit",   oRE_BIT,   e_re);
        chk("data",     oDATA,     e_data);
        chk("tx_valid", oTX_VALID, e_txv);
        chk("tx_data",  oTX_DATA,  e_txd);
        chk("err_cnt",  oERR_CNT,  e_err);
        if (oWE_BIT != 16'h0) begin we_cycles++; last_we = oWE_BIT; end
        if (oRE_BIT != 16'h0) begin re_cycles++; last_re = oRE_BIT; end
        if (oTX_VALID && iTX_READY) begin tx_cnt++; last_txd = oTX_DATA; end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        iRX_DATA  = b;
        iRX_VALID = 1'b1;
        while (!oRX_READY && n < 200) begin @(posedge CLK); #1; n++; end
        if (n >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: byte 0x%0h not accepted within 200 cycles", b);
        end
        @(posedge CLK); #1;
        iRX_VALID = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("reset_outputs", {oWE_BIT, oRE_BIT, oDATA, oTX_DATA, oTX_VALID, oERR_CNT, oRX_READY}, 32'h0);
        RST_N = 1'b1;
        tick(2);
        chk("idle_ready", oRX_READY, 1'b1);

        // Write 0x5A to register 3
        send_byte(8'h83); send_byte(8'h5A); tick(3);
        chk("w_data", oDATA, 8'h5A);
        chk("w_pulses", we_cycles, 1);
        chk("w_strobe", last_we, 16'h0008);
        chk("w_no_tx", tx_cnt, 0);

        // Read register 2 with back-pressure
        iTX_READY = 1'b0; rd_val = 8'h3C;
        send_byte(8'h02); tick(2); tick(5);
        chk("r_valid_held", oTX_VALID, 1'b1);
        chk("r_data", oTX_DATA, 8'h3C);
        chk("r_pulses", re_cycles, 1);
        chk("r_select", last_re, 16'h0004);
        iTX_READY = 1'b1; tick(2);
        chk("r_handshake", tx_cnt, 1);

        // Reserved bits, then an out-of-range read
        send_byte(8'hA1); tick(2);
        chk("rsv_err", oERR_CNT, 8'd1);
        send_byte(8'h1F); tick(4);
        chk("oor_err", oERR_CNT, 8'd2);
        chk("oor_resp", last_txd, 8'h00);
        chk("oor_no_sel", re_cycles, 1);

        // Write timeout, then a normal write
        send_byte(8'h81); tick(TO_CYC + 3);
        chk("to_err", oERR_CNT, 8'd3);
        chk("to_idle", oBUSY, 1'b0);
        chk("to_no_we", we_cycles, 1);
        send_byte(8'h81); send_byte(8'h11); tick(3);
        chk("after_to_we", last_we, 16'h0002);
        chk("after_to_data", oDATA, 8'h11);

        // Reset in WDATA
        send_byte(8'h85); tick(1);
        RST_N = 1'b0; tick(2);
        chk("rst_wdata", {oWE_BIT, oRE_BIT, oDATA, oTX_DATA, oTX_VALID, oERR_CNT, oBUSY}, 32'h0);
        RST_N = 1'b1; tick(3);
        chk("rst_wdata_no_we", we_cycles, 2);

        // Reset in TX
        iTX_READY = 1'b0; rd_val = 8'h77;
        send_byte(8'h03); tick(3);
        chk("pre_rst_tx", oTX_VALID, 1'b1);
        RST_N = 1'b0; tick(2);
        chk("rst_tx", {oTX_VALID, oTX_DATA, oERR_CNT, oRX_READY}, 32'h0);
        RST_N = 1'b1; iTX_READY = 1'b1; tick(3);
        chk("rst_tx_no_hs", tx_cnt, 2);

        // Timeout coinciding with the data byte: counted once, byte still written
        send_byte(8'h84); tick(TO_CYC - 1);
        send_byte(8'hC3); tick(3);
        chk("coinc_err", oERR_CNT, 8'd1);
        chk("coinc_we", last_we, 16'h0010);
        chk("coinc_data", oDATA, 8'hC3);

        // Saturation
        for (int i = 0; i < 300; i++) send_byte(8'h40 | 8'(i & 31));
        tick(2);
        chk("err_sat", oERR_CNT, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
